// File: rtl/chunked_add_sequencer_pkg.sv
// Shared definitions for the chunked add sequencer.
//   state_t      : sequencer FSM encoding (IDLE / RUN / DONE)
//   DEF_W, DEF_K : default total operand width and chunk width
//   clog2()      : ceiling log2, used to size the chunk index counter
package addseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W = 128;
    localparam int DEF_K = 32;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/chunked_add_sequencer_if.sv
// Requester-side bundle of the chunked add sequencer.
//   start/a/b/c_in/abort/ack : driven by the requester (master)
//   ready/busy/done/sum/c_out: driven by the sequencer (slave)
interface chunked_add_sequencer_if #(
    parameter int W = 128
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         abort;
    logic         ack;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    modport master (
        output start, a, b, c_in, abort, ack,
        input  ready, busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in, abort, ack,
        output ready, busy, done, sum, c_out
    );
endinterface

// File: rtl/chunked_add_sequencer_adder.sv
// n_ripple_adder: K-bit combinational ripple-carry adder, the narrow datapath
// that the sequencer reuses once per chunk.
//   a, b  : K-bit operands
//   c_in  : carry into bit 0
//   sum   : K-bit result
//   c_out : carry out of bit K-1
module n_ripple_adder
    import addseq_pkg::*;
#(
    parameter int K = DEF_K
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         c_in,
    output logic [K-1:0] sum,
    output logic         c_out
);

    logic [K:0] carry;

    assign carry[0] = c_in;

    for (genvar gi = 0; gi < K; gi++) begin : g_bit
        assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign c_out = carry[K];

endmodule

// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: computes a W-bit a + b + c_in by running one K-bit
// ripple adder over N = W/K consecutive cycles, least-significant chunk first.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : requester bundle (slave side): start/ready accept handshake,
//           done/ack completion handshake, abort cancel, registered sum/c_out
module chunked_add_sequencer
    import addseq_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int K = DEF_K
) (
    input  logic                    clk,
    input  logic                    rst_n,
    chunked_add_sequencer_if.slave  bus
);

    localparam int N  = W / K;
    localparam int CW = (N > 1) ? clog2(N) : 1;

    if ((K < 1) || (K > W) || ((W % K) != 0)) begin : g_bad_params
        $error("chunked_add_sequencer: W must be a positive multiple of K");
    end

    state_t         state_reg;
    state_t         state_next;
    logic [CW-1:0]  idx_reg;
    logic           carry_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           c_out_reg;
    logic [K-1:0]   sum_chunk_reg [N];

    logic [K-1:0]   chunk_a;
    logic [K-1:0]   chunk_b;
    logic [K-1:0]   chunk_sum;
    logic           chunk_c;
    logic           last_chunk;
    logic           accept;
    logic           step;
    logic [W-1:0]   sum_flat;

    assign accept     = (state_reg == IDLE) && bus.start && !bus.abort;
    // A RUN cycle only commits its chunk when it is not being aborted, so an
    // aborted operation leaves exactly the chunks completed before the abort.
    assign step       = (state_reg == RUN) && !bus.abort;
    assign last_chunk = (idx_reg == CW'(N - 1));

    // Chunk operand select; compare-based so an index past N-1 selects zero.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_reg == CW'(i)) begin
                chunk_a = a_reg[i*K +: K];
                chunk_b = b_reg[i*K +: K];
            end
        end
    end

    n_ripple_adder #(.K(K)) u_adder (
        .a     (chunk_a),
        .b     (chunk_b),
        .c_in  (carry_reg),
        .sum   (chunk_sum),
        .c_out (chunk_c)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state; abort outranks ack in DONE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = RUN;
            RUN: begin
                if (bus.abort)       state_next = IDLE;
                else if (last_chunk) state_next = DONE;
            end
            DONE: if (bus.abort || bus.ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk index, inter-chunk carry and final carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            c_out_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.c_in;
            idx_reg   <= '0;
        end else if (step) begin
            carry_reg <= chunk_c;
            idx_reg   <= idx_reg + CW'(1);
            if (last_chunk) begin
                c_out_reg <= chunk_c;
            end
        end
    end

    // One register per result chunk; each is written only on its own RUN
    // cycle, and is never cleared at accept.
    for (genvar gi = 0; gi < N; gi++) begin : g_chunk
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_chunk_reg[gi] <= '0;
            end else if (step && (idx_reg == CW'(gi))) begin
                sum_chunk_reg[gi] <= chunk_sum;
            end
        end
    end

    always_comb begin
        sum_flat = '0;
        for (int i = 0; i < N; i++) begin
            sum_flat[i*K +: K] = sum_chunk_reg[i];
        end
    end

    // Outputs decoded from registered state only
    assign bus.ready = (state_reg == IDLE);
    assign bus.busy  = (state_reg == RUN);
    assign bus.done  = (state_reg == DONE);
    assign bus.sum   = sum_flat;
    assign bus.c_out = c_out_reg;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Testbench for chunked_add_sequencer: a W=128/K=32 instance and an N=1
// (K=W=128) instance, each with an expected-result queue checked by its own
// monitor whenever done rises.
module tb_chunked_add_sequencer;
    import addseq_pkg::*;

    localparam int W  = 128;
    localparam int K  = 32;
    localparam int N  = W / K;
    localparam int K1 = 128;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    chunked_add_sequencer_if #(.W(W)) bus ();
    chunked_add_sequencer_if #(.W(W)) bus1 ();

    chunked_add_sequencer #(.W(W), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    chunked_add_sequencer #(.W(W), .K(K1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp1_q[$];

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t       e;
        logic [W:0] full;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum = full[W-1:0];
        e.c   = full[W];
        return e;
    endfunction

    // Monitors: one comparison per rising edge of done
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done");
                end else begin
                    e = exp_q.pop_front();
                    check("result", {bus.c_out, bus.sum}, {e.c, e.sum});
                end
            end
            prev = bus.done;
        end
    end

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.done && !prev) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done_n1 actual=done required=no_done");
                end else begin
                    e = exp1_q.pop_front();
                    check("result_n1", {bus1.c_out, bus1.sum}, {e.c, e.sum});
                end
            end
            prev = bus1.done;
        end
    end

    // Full operation on the K=32 instance with exact latency checks
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input exp_t e, input string tag);
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.c_in = c;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy0"}, {{W{1'b0}}, bus.busy}, 1);
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, {{W{1'b0}}, bus.busy}, 1);
        end
        @(negedge clk);
        check({tag, "_done_latency"}, {{W{1'b0}}, bus.done}, 1);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check({tag, "_ready_after_ack"}, {{W{1'b0}}, bus.ready}, 1);
    endtask

    task automatic run_op1(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input exp_t e);
        exp1_q.push_back(e);
        @(negedge clk);
        bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.c_in = c;
        @(negedge clk);
        bus1.start = 1'b0;
        check("n1_busy", {{W{1'b0}}, bus1.busy}, 1);
        @(negedge clk);
        check("n1_done_latency", {{W{1'b0}}, bus1.done}, 1);
        bus1.ack = 1'b1;
        @(negedge clk);
        bus1.ack = 1'b0;
        check("n1_ready_after_ack", {{W{1'b0}}, bus1.ready}, 1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        exp_t         e;

        rst_n = 1'b0;
        bus.start = 0; bus.a = '0; bus.b = '0; bus.c_in = 0; bus.abort = 0; bus.ack = 0;
        bus1.start = 0; bus1.a = '0; bus1.b = '0; bus1.c_in = 0; bus1.abort = 0; bus1.ack = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ready", {{W{1'b0}}, bus.ready}, 1);
        check("rst_busy",  {{W{1'b0}}, bus.busy}, 0);
        check("rst_done",  {{W{1'b0}}, bus.done}, 0);
        check("rst_sum_cout", {bus.c_out, bus.sum}, '0);
        check("rst_ready_n1", {{W{1'b0}}, bus1.ready}, 1);

        // start together with abort in IDLE is not accepted
        bus.start = 1'b1; bus.abort = 1'b1; bus.a = '1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_ready", {{W{1'b0}}, bus.ready}, 1);
        check("start_abort_busy",  {{W{1'b0}}, bus.busy}, 0);

        // Full carry ripple through all chunks
        e.sum = '0; e.c = 1'b1;
        run_op('1, '0, 1'b1, e, "ripple");
        $display("op ripple: sum=%h c_out=%b", bus.sum, bus.c_out);

        // Carry across the first chunk boundary
        e.sum = 128'h0000_0000_0000_0000_0000_0001_0000_0000; e.c = 1'b0;
        run_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, e, "boundary");
        $display("op boundary: sum=%h c_out=%b", bus.sum, bus.c_out);

        // Handshake: start during RUN and DONE ignored, done held without ack
        e.sum = 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_1111_1112; e.c = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 128'hF234_5678_9ABC_DEF0_0F0F_0F0F_1111_1111;
        bus.b = 128'h2000_0000_0000_0000_0000_0000_0000_0001;
        bus.c_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("hs_busy_t0", {{W{1'b0}}, bus.busy}, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 128'h5; bus.b = 128'h7; bus.c_in = 1'b1;
        check("hs_busy_t1", {{W{1'b0}}, bus.busy}, 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("hs_busy_t2", {{W{1'b0}}, bus.busy}, 1);
        @(negedge clk);
        check("hs_busy_t3", {{W{1'b0}}, bus.busy}, 1);
        @(negedge clk);
        check("hs_done_latency", {{W{1'b0}}, bus.done}, 1);
        for (int i = 0; i < 10; i++) begin
            bus.start = (i < 3);
            bus.a = 128'h99; bus.b = 128'h11;
            @(negedge clk);
            check("hs_done_held", {{W{1'b0}}, bus.done}, 1);
            check("hs_sum_stable", {bus.c_out, bus.sum}, {e.c, e.sum});
        end
        bus.start = 1'b1; bus.ack = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.ack = 1'b0;
        check("hs_ack_start_ready", {{W{1'b0}}, bus.ready}, 1);
        check("hs_ack_start_done", {{W{1'b0}}, bus.done}, 0);
        @(negedge clk);
        check("hs_no_accept_busy", {{W{1'b0}}, bus.busy}, 0);
        check("hs_no_accept_ready", {{W{1'b0}}, bus.ready}, 1);
        $display("op handshake: sum=%h c_out=%b", bus.sum, bus.c_out);

        // Abort in RUN after two chunks
        @(negedge clk);
        bus.start = 1'b1; bus.a = {32{4'h5}}; bus.b = {32{4'h5}}; bus.c_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_ready", {{W{1'b0}}, bus.ready}, 1);
        check("abort_busy",  {{W{1'b0}}, bus.busy}, 0);
        check("abort_done",  {{W{1'b0}}, bus.done}, 0);
        check("abort_partial_sum", {bus.c_out, bus.sum},
              {1'b1, 128'h1234_5678_9ABC_DEF0_AAAA_AAAA_AAAA_AAAA});
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", {{W{1'b0}}, bus.done}, 0);
        end
        $display("op abort: sum=%h c_out=%b", bus.sum, bus.c_out);
        e.sum = {32{4'hA}}; e.c = 1'b0;
        run_op({32{4'h5}}, {32{4'h5}}, 1'b0, e, "after_abort");
        $display("op after_abort: sum=%h c_out=%b", bus.sum, bus.c_out);

        // Asynchronous reset mid-RUN, off the clock edge
        @(negedge clk);
        bus.start = 1'b1; bus.a = 128'h1; bus.b = 128'h2; bus.c_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_ready", {{W{1'b0}}, bus.ready}, 1);
        check("areset_busy",  {{W{1'b0}}, bus.busy}, 0);
        check("areset_sum_cout", {bus.c_out, bus.sum}, '0);
        $display("op async_reset: ready=%b sum=%h", bus.ready, bus.sum);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random operations against a + b + c_in
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = '1; rb = '1; rc = 1'b1; end
            run_op(ra, rb, rc, golden(ra, rb, rc), "rand");
            $display("op rand %0d: a=%h b=%h c_in=%b sum=%h c_out=%b", i, ra, rb, rc, bus.sum, bus.c_out);
        end

        // N=1 build: single RUN cycle
        e.sum = '0; e.c = 1'b1;
        run_op1('1, '0, 1'b1, e);
        $display("op n1 ripple: sum=%h c_out=%b", bus1.sum, bus1.c_out);
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            run_op1(ra, rb, rc, golden(ra, rb, rc));
            $display("op n1 rand %0d: sum=%h c_out=%b", i, bus1.sum, bus1.c_out);
        end

        repeat (3) @(negedge clk);
        check("pending_results", W'(exp_q.size() + exp1_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
